instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 38 +++
 rtl/instr_pack.sv | 75 +++++++
 rtl/instr_encoder.sv | 140 ++++++++++++++
 tb/tb_instr_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared types and constants for the RV32I instruction encoder.
//                Holds the instruction-kind enum, the major opcodes and the
//                encoder state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    // Instruction kinds presented on the encoder's kind input.
    // The codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        KIND_LW        = 3'd0,
        KIND_SW        = 3'd1,
        KIND_RTYPE     = 3'd2,
        KIND_BEQ       = 3'd3,
        KIND_ITYPE_ALU = 3'd4,
        KIND_JAL       = 3'd5
    } kind_e;

    // RV32I major opcodes, instr[6:0]
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    // Encoder control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pack
//  Description : Purely combinational RV32I field packer. Turns the decoded
//                instruction fields into a 32-bit instruction word and flags
//                whether the kind/immediate combination is encodable.
//  Ports       : kind, rd, rs1, rs2, funct3, funct7b5, imm  - fields in
//                word  - packed instruction word (zero when illegal)
//                legal - kind is known and immediate is in range
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [20:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic w_fits12;
    logic w_fits13;
    logic w_even;

    // A value fits an N-bit signed field when every bit above the field's
    // sign bit is a copy of that sign bit.
    assign w_fits12 = (imm[20:11] == {10{imm[11]}});
    assign w_fits13 = (imm[20:12] == {9{imm[12]}});
    assign w_even   = ~imm[0];

    always_comb begin
        word  = 32'd0;
        legal = 1'b0;
        case (kind)
            KIND_LW: begin
                word  = {imm[11:0], rs1, 3'b010, rd, c_OP_LOAD};
                legal = w_fits12;
            end
            KIND_SW: begin
                word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], c_OP_STORE};
                legal = w_fits12;
            end
            KIND_RTYPE: begin
                word  = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, c_OP_RTYPE};
                legal = 1'b1;
            end
            KIND_BEQ: begin
                word  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11],
                         c_OP_BRANCH};
                legal = w_fits13 & w_even;
            end
            KIND_ITYPE_ALU: begin
                word  = {imm[11:0], rs1, funct3, rd, c_OP_IMM};
                legal = w_fits12;
            end
            KIND_JAL: begin
                // The 21-bit input already spans the whole JAL range, so only
                // alignment can fail.
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, c_OP_JAL};
                legal = w_even;
            end
            default: begin
                word  = 32'd0;
                legal = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Accepts decoded instruction fields over a valid/ready
//                handshake, encodes them to RV32I words and writes them to
//                consecutive instruction-memory addresses from a base address.
//  Ports       : clk, reset (async, active low)
//                start, base_addr          - begin a new program
//                in_valid/in_ready + fields - instruction input
//                imem_we/imem_addr/imem_wdata - memory write port (registered)
//                count, full, err          - program status
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [20:0] imm,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [15:0] count,
    output logic        full,
    output logic        err
);

    // Count value held just before the final word is accepted. With
    // DEPTH = 65536 the 16-bit count wraps to zero on the final word; the
    // full flag is taken from the state, so it is still reported correctly.
    localparam logic [15:0] c_LAST = 16'(DEPTH - 1);

    state_e      r_state;
    state_e      w_state_nxt;

    logic [31:0] r_next_addr;
    logic [15:0] r_count;
    logic        r_err;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_xfer;
    logic        w_last;

    instr_pack u_pack (
        .kind     (kind),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .imm      (imm),
        .word     (w_word),
        .legal    (w_legal)
    );

    // start wins over a transfer presented in the same cycle.
    assign w_xfer = in_valid && (r_state == ST_ACTIVE) && !start;
    assign w_last = (r_count == c_LAST);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_ACTIVE;
        end else if (w_xfer && w_legal && w_last) begin
            w_state_nxt = ST_FULL;
        end
    end

    // ------------------------------------------------------------------
    // Address/count tracking and registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_next_addr <= 32'd0;
            r_count     <= 16'd0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
        end else begin
            // Write strobe is a one-cycle pulse; an in-flight write still
            // completes during a restart because its address was already
            // latched into r_addr.
            r_we <= 1'b0;
            if (start) begin
                r_next_addr <= base_addr;
                r_count     <= 16'd0;
                r_err       <= 1'b0;
            end else if (w_xfer) begin
                if (w_legal) begin
                    r_we        <= 1'b1;
                    r_addr      <= r_next_addr;
                    r_wdata     <= w_word;
                    r_next_addr <= r_next_addr + 32'd4;
                    r_count     <= r_count + 16'd1;
                end else begin
                    // Illegal transfers are consumed silently apart from err.
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = (r_state == ST_ACTIVE);
    assign full       = (r_state == ST_FULL);
    assign count      = r_count;
    assign err        = r_err;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder. Stimulus updates a
//                behavioural model and queues expected memory writes; a
//                monitor pops and compares on every write strobe and checks
//                the status outputs each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int c_DEPTH = 4;

    localparam int K_LW    = 0;
    localparam int K_SW    = 1;
    localparam int K_RTYPE = 2;
    localparam int K_BEQ   = 3;
    localparam int K_ITYPE = 4;
    localparam int K_JAL   = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  kind = 3'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7b5 = 1'b0;
    logic [20:0] imm = 21'd0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [15:0] count;
    logic        full;
    logic        err;

    instr_encoder #(.DEPTH(c_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .kind       (kind),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .imm        (imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];

    // Behavioural model of the program being written
    bit          m_open  = 1'b0;
    bit          m_full  = 1'b0;
    bit          m_err   = 1'b0;
    int          m_count = 0;
    logic [31:0] m_addr  = 32'd0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built with shifts and masks on the integer immediate.
    function automatic logic [31:0] ref_word(input int k, input int r_d, input int r_s1,
                                             input int r_s2, input int f3, input int f7,
                                             input int im);
        logic [31:0] u;
        logic [31:0] w;
        u = im;
        w = 32'd0;
        case (k)
            K_LW:    w = ((u & 32'hFFF) << 20) | (r_s1 << 15) | (2 << 12) | (r_d << 7) | 32'h03;
            K_SW:    w = (((u >> 5) & 32'h7F) << 25) | (r_s2 << 20) | (r_s1 << 15) | (2 << 12)
                         | ((u & 32'h1F) << 7) | 32'h23;
            K_RTYPE: w = (f7 << 30) | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | 32'h33;
            K_BEQ:   w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r_s2 << 20)
                         | (r_s1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7)
                         | 32'h63;
            K_ITYPE: w = ((u & 32'hFFF) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | 32'h13;
            K_JAL:   w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                         | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
                         | (r_d << 7) | 32'h6F;
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic bit ref_legal(input int k, input int im);
        case (k)
            K_LW, K_SW, K_ITYPE: return (im >= -2048) && (im <= 2047);
            K_RTYPE:             return 1'b1;
            K_BEQ:               return (im >= -4096) && (im <= 4094) && ((im % 2) == 0);
            K_JAL:               return (im % 2) == 0;
            default:             return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_open  = 1'b0;
        m_full  = 1'b0;
        m_err   = 1'b0;
        m_count = 0;
        m_addr  = 32'd0;
        q.delete();
    endtask

    // Drive one cycle of stimulus, let the DUT sample it, update the model.
    task automatic step(input bit st, input logic [31:0] base, input bit v, input int k,
                        input int r_d, input int r_s1, input int r_s2, input int f3,
                        input int f7, input int im);
        wr_t e;
        start     = st;
        base_addr = base;
        in_valid  = v;
        kind      = k[2:0];
        rd        = r_d[4:0];
        rs1       = r_s1[4:0];
        rs2       = r_s2[4:0];
        funct3    = f3[2:0];
        funct7b5  = f7[0];
        imm       = im[20:0];
        @(posedge clk);
        if (st) begin
            m_open  = 1'b1;
            m_full  = 1'b0;
            m_addr  = base;
            m_count = 0;
            m_err   = 1'b0;
        end else if (v && m_open) begin
            if (ref_legal(k, im)) begin
                e.addr = m_addr;
                e.data = ref_word(k, r_d, r_s1, r_s2, f3, f7, im);
                q.push_back(e);
                m_addr  = m_addr + 32'd4;
                m_count = m_count + 1;
                if (m_count == c_DEPTH) begin
                    m_open = 1'b0;
                    m_full = 1'b1;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, 32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Monitor: write port against the scoreboard, status against the model.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (imem_we) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write at %0t",
                                 imem_addr, imem_wdata, $time);
                    end else begin
                        e = q.pop_front();
                        chk("wr_addr", imem_addr, e.addr);
                        chk("wr_data", imem_wdata, e.data);
                    end
                end else if (q.size() != 0) begin
                    e = q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_write: got imem_we 0 expected write 0x%08h @0x%08h at %0t",
                             e.data, e.addr, $time);
                end
                chk("in_ready", 32'(in_ready), 32'(m_open));
                chk("full", 32'(full), 32'(m_full));
                chk("err", 32'(err), 32'(m_err));
                chk("count", 32'(count), 32'(m_count[15:0]));
            end
        end
    end

    initial begin
        int k, im;
        // Reset state
        #2 reset = 1'b0;
        #10;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        idle();

        // Single LW
        step(1'b1, 32'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 32'd0, 1'b1, K_LW, 6, 9, 0, 0, 0, -4);
        @(negedge clk);
        chk("lw_we", 32'(imem_we), 32'd1);
        chk("lw_addr", imem_addr, 32'h0);
        chk("lw_word", imem_wdata, 32'hFFC4A303);

        // Back-to-back SW then RTYPE
        step(1'b1, 32'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 32'd0, 1'b1, K_SW, 0, 9, 6, 0, 0, 8);
        @(negedge clk);
        chk("sw_addr", imem_addr, 32'h0);
        chk("sw_word", imem_wdata, 32'h0064A423);
        step(1'b0, 32'd0, 1'b1, K_RTYPE, 4, 5, 6, 6, 0, 0);
        @(negedge clk);
        chk("rtype_we", 32'(imem_we), 32'd1);
        chk("rtype_addr", imem_addr, 32'h4);
        chk("rtype_word", imem_wdata, 32'h0062E233);
        chk("count_two", 32'(count), 32'd2);

        // BEQ, then misaligned JAL
        step(1'b0, 32'd0, 1'b1, K_BEQ, 0, 4, 4, 0, 0, 8);
        @(negedge clk);
        chk("beq_word", imem_wdata, 32'h00420463);
        chk("beq_addr", imem_addr, 32'h8);
        step(1'b0, 32'd0, 1'b1, K_JAL, 0, 0, 0, 0, 0, 3);
        @(negedge clk);
        chk("jal_bad_we", 32'(imem_we), 32'd0);
        chk("jal_bad_err", 32'(err), 32'd1);
        chk("jal_bad_count", 32'(count), 32'd3);

        // Fill to DEPTH with one extra transfer, then restart
        step(1'b1, 32'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'd0, 1'b1, K_ITYPE, i + 1, i + 2, 0, i, 0, 16 * i - 20);
        end
        @(negedge clk);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_count", 32'(count), 32'd4);
        step(1'b1, 32'h100, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("restart_in_ready", 32'(in_ready), 32'd1);
        chk("restart_count", 32'(count), 32'd0);
        chk("restart_err", 32'(err), 32'd0);
        step(1'b0, 32'd0, 1'b1, K_LW, 1, 2, 0, 0, 0, 100);
        @(negedge clk);
        chk("restart_addr", imem_addr, 32'h100);

        // Illegal kind
        step(1'b0, 32'd0, 1'b1, 7, 1, 2, 3, 0, 0, 0);
        @(negedge clk);
        chk("kind7_err", 32'(err), 32'd1);
        chk("kind7_we", 32'(imem_we), 32'd0);

        // Reset with a write pending
        step(1'b1, 32'h40, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 32'd0, 1'b1, K_LW, 3, 4, 0, 0, 0, 12);
        reset = 1'b0;
        model_reset();
        #1;
        check_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b1, K_LW, 3, 4, 0, 0, 0, 12);
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                im = int'($urandom_range(0, 2097151)) - 1048576;
            end else begin
                im = int'($urandom_range(0, 8191)) - 4096;
            end
            if ($urandom_range(0, 1) == 1) begin
                im = im & ~1;
            end
            step($urandom_range(0, 7) == 0, $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) != 0, k,
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)), im);
        end
        idle();
        idle();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
